boot_loader: RTL and testbench

// - Sits upstream of the pipelined RISC-V core and its instruction memory.
// - Accepts a byte stream over valid/ready.
// - Packs the bytes into 32-bit little-endian words and writes them into instruction memory from word address 0.
// - Holds the core in reset (core_srst) until the image is complete, then releases it after a fixed delay.

---
 rtl/boot_pkg.sv | 18 +
 rtl/boot_word_packer.sv | 53 +++++
 rtl/boot_loader.sv | 148 ++++++++++++++
 tb/tb_boot_loader.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_pkg.sv
// Shared types and constants for the boot loader: FSM state encoding and counter sizing.
package boot_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    DATA,
    RELEASE,
    RUN,
    ERR
  } boot_state_e;

  localparam int unsigned HDR_BYTES = 2;
  // 17 bits so a full 2**16-word count compares exactly without wrapping.
  localparam int unsigned CntW = 17;

endpackage

// File: rtl/boot_word_packer.sv
// Packs a little-endian byte stream into 32-bit words; word_valid pulses for one cycle
// after the fourth byte of each word is accepted.
module boot_word_packer
  import boot_pkg::*;
(
  input  logic        clk,
  input  logic        srst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_last,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  idx_q;
  logic [23:0] part_q;
  logic [31:0] word_q;
  logic        valid_q;

  // Accepted byte completes the current word.
  assign word_last  = byte_valid && (idx_q == 2'd3);
  assign word       = word_q;
  assign word_valid = valid_q;

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      idx_q   <= 2'd0;
      part_q  <= 24'd0;
      word_q  <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (clear) begin
        idx_q  <= 2'd0;
        part_q <= 24'd0;
      end else if (byte_valid) begin
        idx_q <= idx_q + 2'd1;
        unique case (idx_q)
          2'd0: part_q[7:0]   <= byte_data;
          2'd1: part_q[15:8]  <= byte_data;
          2'd2: part_q[23:16] <= byte_data;
          2'd3: begin
            word_q  <= {byte_data, part_q};
            valid_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/boot_loader.sv
// Streams a length-prefixed byte image into instruction memory and holds the core in reset
// until the image is written, releasing it a fixed number of cycles afterwards.
module boot_loader
  import boot_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned RELEASE_DLY = 4
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              start,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_srst,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [CntW-1:0] Capacity = CntW'(1) << ADDR_W;
  localparam int unsigned     DlyW     = $clog2(RELEASE_DLY + 1);
  localparam logic [DlyW-1:0] DlyLast  = DlyW'(RELEASE_DLY - 1);

  boot_state_e     state_q;
  logic [15:0]     n_q;
  logic [CntW-1:0] word_cnt_q;
  logic [CntW-1:0] words_in_q;
  logic [DlyW-1:0] dly_q;

  logic            xfer;
  logic [15:0]     n_hdr;
  logic            pack_valid;
  logic            pack_clear;
  logic            word_last;
  logic [CntW-1:0] word_cnt_inc;
  logic [CntW-1:0] words_in_inc;

  assign xfer         = s_valid && s_ready;
  assign n_hdr        = {s_data, n_q[7:0]};
  assign pack_valid   = xfer && (state_q == DATA);
  assign pack_clear   = start && ((state_q == IDLE) || (state_q == RUN));
  assign word_cnt_inc = word_cnt_q + CntW'(1);
  assign words_in_inc = words_in_q + CntW'(1);
  assign imem_addr    = word_cnt_q[ADDR_W-1:0];

  boot_word_packer u_packer (
    .clk        (clk),
    .srst       (srst),
    .clear      (pack_clear),
    .byte_valid (pack_valid),
    .byte_data  (s_data),
    .word_last  (word_last),
    .word       (imem_wdata),
    .word_valid (imem_we)
  );

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      state_q    <= IDLE;
      n_q        <= 16'd0;
      word_cnt_q <= '0;
      words_in_q <= '0;
      dly_q      <= '0;
      s_ready    <= 1'b0;
      core_srst  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= HDR0;
            s_ready <= 1'b1;
            busy    <= 1'b1;
          end
        end
        HDR0: begin
          if (xfer) begin
            n_q[7:0] <= s_data;
            state_q  <= HDR1;
          end
        end
        HDR1: begin
          if (xfer) begin
            n_q[15:8] <= s_data;
            if (n_hdr == 16'd0) begin
              state_q <= RELEASE;
              s_ready <= 1'b0;
              dly_q   <= '0;
            end else if (CntW'(n_hdr) > Capacity) begin
              state_q <= ERR;
              s_ready <= 1'b0;
              busy    <= 1'b0;
              err     <= 1'b1;
            end else begin
              state_q <= DATA;
            end
          end
        end
        DATA: begin
          // Stop accepting as soon as the final byte of the image is in.
          if (word_last) begin
            words_in_q <= words_in_inc;
            if (words_in_inc == CntW'(n_q)) s_ready <= 1'b0;
          end
          if (imem_we) begin
            word_cnt_q <= word_cnt_inc;
            if (word_cnt_inc == CntW'(n_q)) begin
              state_q <= RELEASE;
              dly_q   <= '0;
            end
          end
        end
        RELEASE: begin
          if (dly_q == DlyLast) begin
            state_q   <= RUN;
            core_srst <= 1'b0;
            done      <= 1'b1;
            busy      <= 1'b0;
          end else begin
            dly_q <= dly_q + DlyW'(1);
          end
        end
        RUN: begin
          if (start) begin
            state_q    <= HDR0;
            core_srst  <= 1'b1;
            done       <= 1'b0;
            busy       <= 1'b1;
            s_ready    <= 1'b1;
            n_q        <= 16'd0;
            word_cnt_q <= '0;
            words_in_q <= '0;
            dly_q      <= '0;
          end
        end
        ERR: state_q <= ERR;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Scoreboard bench for boot_loader: expected imem writes are queued as bytes are driven and
// popped by a write monitor.
module tb_boot_loader;

  localparam int unsigned ADDR_W      = 8;
  localparam int unsigned RELEASE_DLY = 4;

  logic              clk = 1'b0;
  logic              srst = 1'b0;
  logic              start = 1'b0;
  logic              s_valid = 1'b0;
  logic [7:0]        s_data = 8'd0;
  logic              s_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_srst;
  logic              busy;
  logic              done;
  logic              err;

  boot_loader #(
    .ADDR_W      (ADDR_W),
    .RELEASE_DLY (RELEASE_DLY)
  ) dut (
    .clk        (clk),
    .srst       (srst),
    .start      (start),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_srst  (core_srst),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        e;
  logic [7:0] stream[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         wr_cnt = 0;
  int         last_we_cyc = 0;
  logic [7:0] last_we_addr = 8'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (imem_we) begin
      wr_cnt++;
      last_we_cyc  = cyc;
      last_we_addr = imem_addr;
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(imem_addr), 32'(e.addr));
        check("wr_data", imem_wdata, e.data);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic push_word(input logic [7:0] a, input logic [31:0] d);
    exp_q.push_back('{addr: a, data: d});
    for (int i = 0; i < 4; i++) stream.push_back(d[8*i +: 8]);
  endtask

  // Returns the cycle whose closing edge accepts the byte.
  task automatic send_byte(input logic [7:0] b, output int xcyc);
    int t;
    t = 0;
    xcyc = 0;
    s_valid = 1'b1;
    s_data  = b;
    while (1) begin
      @(negedge clk);
      if (s_ready) begin
        xcyc = cyc;
        break;
      end
      t++;
      if (t > 100) begin
        check("ready_timeout", 32'd0, 32'd1);
        s_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_data  = 8'($urandom);
  endtask

  task automatic send_stream(input int gap, input int mid_at, output int hdr_cyc);
    int x;
    hdr_cyc = 0;
    for (int i = 0; i < stream.size(); i++) begin
      send_byte(stream[i], x);
      if (i == 1) hdr_cyc = x;
      if (i == mid_at) idle(10);
      else if (gap > 0) idle(gap);
    end
    stream.delete();
  endtask

  // Delay is measured from the edge that commits the last write (or the header byte).
  task automatic wait_release(input string tag, input int from_cyc, input bit use_we);
    int t;
    int from;
    t = 0;
    while (core_srst) begin
      @(negedge clk);
      t++;
      if (t > 2000) begin
        check({tag, "_timeout"}, 32'd0, 32'd1);
        return;
      end
    end
    from = use_we ? last_we_cyc + 1 : from_cyc + 1;
    check({tag, "_dly"}, 32'(cyc - from), RELEASE_DLY);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"}, 32'(s_ready), 32'd0);
    check({tag, "_we"}, 32'(imem_we), 32'd0);
    check({tag, "_addr"}, 32'(imem_addr), 32'd0);
    check({tag, "_wdata"}, imem_wdata, 32'd0);
    check({tag, "_core_srst"}, 32'(core_srst), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hc;
    int w0;

    #2 srst = 1'b1;
    #1 check_reset_outputs("rst");
    #20 srst = 1'b0;
    @(posedge clk);
    #1;
    idle(3);
    check("idle_s_ready", 32'(s_ready), 32'd0);
    check("idle_core_srst", 32'(core_srst), 32'd1);

    // Basic two-word image.
    pulse_start();
    check("hdr0_busy", 32'(busy), 32'd1);
    w0 = wr_cnt;
    stream.push_back(8'h02);
    stream.push_back(8'h00);
    push_word(8'd0, 32'h1234_5678);
    push_word(8'd1, 32'hDEAD_BEEF);
    send_stream(0, -1, hc);
    wait_release("basic", 0, 1'b1);
    check("basic_writes", 32'(wr_cnt - w0), 32'd2);
    check("basic_core_srst", 32'(core_srst), 32'd0);

    // Reload from RUN with a one-word image.
    pulse_start();
    check("reload_core_srst", 32'(core_srst), 32'd1);
    check("reload_done", 32'(done), 32'd0);
    w0 = wr_cnt;
    stream.push_back(8'h01);
    stream.push_back(8'h00);
    push_word(8'd0, 32'hDDCC_BBAA);
    send_stream(0, -1, hc);
    wait_release("reload", 0, 1'b1);
    check("reload_writes", 32'(wr_cnt - w0), 32'd1);

    // Stalled stream: one idle cycle between bytes, a long gap mid-word.
    pulse_start();
    w0 = wr_cnt;
    stream.push_back(8'h02);
    stream.push_back(8'h00);
    push_word(8'd0, 32'h1234_5678);
    push_word(8'd1, 32'hDEAD_BEEF);
    send_stream(1, 7, hc);
    wait_release("stall", 0, 1'b1);
    check("stall_writes", 32'(wr_cnt - w0), 32'd2);

    // Empty image.
    pulse_start();
    w0 = wr_cnt;
    stream.push_back(8'h00);
    stream.push_back(8'h00);
    send_stream(0, -1, hc);
    wait_release("empty", hc, 1'b0);
    check("empty_writes", 32'(wr_cnt - w0), 32'd0);

    // Reset mid-load after two payload bytes.
    pulse_start();
    stream.push_back(8'h01);
    stream.push_back(8'h00);
    stream.push_back(8'hAA);
    stream.push_back(8'hBB);
    send_stream(0, -1, hc);
    #3 srst = 1'b1;
    #1 check_reset_outputs("midrst");
    #1 srst = 1'b0;
    @(posedge clk);
    #1;
    pulse_start();
    w0 = wr_cnt;
    stream.push_back(8'h01);
    stream.push_back(8'h00);
    push_word(8'd0, 32'h4433_2211);
    send_stream(0, -1, hc);
    wait_release("fresh", 0, 1'b1);
    check("fresh_writes", 32'(wr_cnt - w0), 32'd1);

    // Full capacity: N == 2**ADDR_W.
    pulse_start();
    w0 = wr_cnt;
    stream.push_back(8'h00);
    stream.push_back(8'h01);
    for (int i = 0; i < 256; i++) begin
      push_word(8'(i), {8'(i), 8'(~i), 8'hC3, 8'(i * 3)});
    end
    send_stream(0, -1, hc);
    wait_release("full", 0, 1'b1);
    check("full_writes", 32'(wr_cnt - w0), 32'd256);
    check("full_last_addr", 32'(last_we_addr), 32'hFF);

    // Oversized header: N == 2**ADDR_W + 1.
    pulse_start();
    w0 = wr_cnt;
    stream.push_back(8'h01);
    stream.push_back(8'h01);
    send_stream(0, -1, hc);
    idle(2);
    check("ovf_err", 32'(err), 32'd1);
    check("ovf_s_ready", 32'(s_ready), 32'd0);
    check("ovf_core_srst", 32'(core_srst), 32'd1);
    check("ovf_busy", 32'(busy), 32'd0);
    pulse_start();
    idle(3);
    check("ovf_sticky_err", 32'(err), 32'd1);
    check("ovf_sticky_s_ready", 32'(s_ready), 32'd0);
    check("ovf_writes", 32'(wr_cnt - w0), 32'd0);
    #3 srst = 1'b1;
    #1 check_reset_outputs("ovf_rst");
    #1 srst = 1'b0;
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
